// File: rtl/seg7_scan_capture.sv
// Scan-bus capture: watches a multiplexed active-low 7-segment display,
// samples each stable digit, decodes it back to hex and assembles a word.
module seg7_scan_capture #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIGITS-1:0]     anode,
    input  logic [6:0]            cathode,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     blank,
    output logic                  value_valid,
    output logic                  seg_err,
    output logic                  anode_err
);

    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] FIRE_AT = CW'(STABLE_CYCLES - 2);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    typedef enum logic {SETTLE, HOLD} state_t;

    logic [DIGITS-1:0]   an_s1_q, an_s2_q, an_prev_q;
    logic [6:0]          ca_s1_q, ca_s2_q, ca_prev_q;
    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                sample, changed;

    logic [3:0]          dec_nib;
    logic                dec_blank, dec_ok;
    logic                any_low, multi_low;
    logic [IW-1:0]       idx;

    logic [4*DIGITS-1:0] shadow_nib_q, shadow_nib_d;
    logic [DIGITS-1:0]   shadow_blank_q, shadow_blank_d;
    logic [DIGITS-1:0]   seen_q, seen_d;
    logic [4*DIGITS-1:0] value_q, value_d;
    logic [DIGITS-1:0]   blank_q, blank_d;
    logic                valid_q, valid_d;
    logic                seg_err_q, seg_err_d;
    logic                anode_err_q, anode_err_d;

    // Two-flop synchronizers plus a previous-value copy for change detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_s1_q   <= '1;
            an_s2_q   <= '1;
            an_prev_q <= '1;
            ca_s1_q   <= '1;
            ca_s2_q   <= '1;
            ca_prev_q <= '1;
        end else begin
            an_s1_q   <= anode;
            an_s2_q   <= an_s1_q;
            an_prev_q <= an_s2_q;
            ca_s1_q   <= cathode;
            ca_s2_q   <= ca_s1_q;
            ca_prev_q <= ca_s2_q;
        end
    end

    assign changed = (an_s2_q != an_prev_q) || (ca_s2_q != ca_prev_q);

    // Stability FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SETTLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Count unchanged cycles; fire once when the pair has held long enough
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sample  = 1'b0;
        case (state_q)
            SETTLE: begin
                if (changed) begin
                    cnt_d = '0;
                end else if (cnt_q == FIRE_AT) begin
                    sample  = 1'b1;
                    cnt_d   = CNT_MAX;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (changed) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = SETTLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Segment pattern back to hex nibble (bit6=g ... bit0=a)
    always_comb begin
        dec_nib   = 4'h0;
        dec_blank = 1'b0;
        dec_ok    = 1'b1;
        case (ca_s2_q)
            7'b1000000: dec_nib = 4'h0;
            7'b1111001: dec_nib = 4'h1;
            7'b0100100: dec_nib = 4'h2;
            7'b0110000: dec_nib = 4'h3;
            7'b0011001: dec_nib = 4'h4;
            7'b0010010: dec_nib = 4'h5;
            7'b0000010: dec_nib = 4'h6;
            7'b1111000: dec_nib = 4'h7;
            7'b0000000: dec_nib = 4'h8;
            7'b0010000: dec_nib = 4'h9;
            7'b0001000: dec_nib = 4'hA;
            7'b0000011: dec_nib = 4'hB;
            7'b0100111: dec_nib = 4'hC;
            7'b0100001: dec_nib = 4'hD;
            7'b0000110: dec_nib = 4'hE;
            7'b0001110: dec_nib = 4'hF;
            7'b1111111: dec_blank = 1'b1;
            default:    dec_ok = 1'b0;
        endcase
    end

    // Classify the anode: none, exactly one (with its index), or several low
    always_comb begin
        any_low   = 1'b0;
        multi_low = 1'b0;
        idx       = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (!an_s2_q[k]) begin
                if (any_low) multi_low = 1'b1;
                any_low = 1'b1;
                idx     = IW'(k);
            end
        end
    end

    // Store samples into the shadow frame and publish it once every digit is seen
    always_comb begin
        shadow_nib_d   = shadow_nib_q;
        shadow_blank_d = shadow_blank_q;
        seen_d         = seen_q;
        value_d        = value_q;
        blank_d        = blank_q;
        valid_d        = 1'b0;
        seg_err_d      = 1'b0;
        anode_err_d    = 1'b0;
        if (sample && any_low) begin
            if (multi_low) begin
                anode_err_d = 1'b1;
            end else if (!dec_ok) begin
                seg_err_d = 1'b1;
            end else begin
                shadow_nib_d[4*idx +: 4] = dec_nib;
                shadow_blank_d[idx]      = dec_blank;
                seen_d[idx]              = 1'b1;
            end
        end
        if (&seen_d) begin
            value_d = shadow_nib_d;
            blank_d = shadow_blank_d;
            valid_d = 1'b1;
            seen_d  = '0;
        end
    end

    // Frame, output and pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_nib_q   <= '0;
            shadow_blank_q <= '0;
            seen_q         <= '0;
            value_q        <= '0;
            blank_q        <= '0;
            valid_q        <= 1'b0;
            seg_err_q      <= 1'b0;
            anode_err_q    <= 1'b0;
        end else begin
            shadow_nib_q   <= shadow_nib_d;
            shadow_blank_q <= shadow_blank_d;
            seen_q         <= seen_d;
            value_q        <= value_d;
            blank_q        <= blank_d;
            valid_q        <= valid_d;
            seg_err_q      <= seg_err_d;
            anode_err_q    <= anode_err_d;
        end
    end

    assign value       = value_q;
    assign blank       = blank_q;
    assign value_valid = valid_q;
    assign seg_err     = seg_err_q;
    assign anode_err   = anode_err_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Bench for seg7_scan_capture: run-length reference model checked every
// cycle, plus literal expectations for each directed scenario.
module tb_seg7_scan_capture;

    localparam int SC = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  anode;
    logic [6:0]  cathode;
    logic [15:0] value;
    logic [3:0]  blank;
    logic        value_valid, seg_err, anode_err;

    int checks = 0;
    int failures = 0;
    int vv_seen = 0, se_seen = 0, ae_seen = 0;

    logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seg7_scan_capture #(.DIGITS(4), .STABLE_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n), .anode(anode), .cathode(cathode),
        .value(value), .blank(blank), .value_valid(value_valid),
        .seg_err(seg_err), .anode_err(anode_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: sampled pair history as a run length, frame as arrays
    logic [10:0] m_s1, m_s2, m_last;
    int          m_run;
    logic [3:0]  m_seen;
    logic [3:0]  m_nib [4];
    logic        m_blk [4];
    logic [15:0] exp_value;
    logic [3:0]  exp_blank;
    logic        exp_vv, exp_se, exp_ae;

    task automatic m_reset();
        m_s1 = '1; m_s2 = '1; m_last = '1; m_run = 1;
        m_seen = '0;
        for (int i = 0; i < 4; i++) begin m_nib[i] = '0; m_blk[i] = 1'b0; end
        exp_value = '0; exp_blank = '0;
        exp_vv = 0; exp_se = 0; exp_ae = 0;
    endtask

    task automatic m_act(input logic [10:0] p);
        logic [3:0] an;
        logic [6:0] ca;
        int zeros, k, nib;
        bit found;
        an = p[10:7];
        ca = p[6:0];
        zeros = 0; k = 0;
        for (int i = 0; i < 4; i++) if (!an[i]) begin zeros++; k = i; end
        if (zeros == 0) return;
        if (zeros > 1) begin exp_ae = 1; return; end
        found = 0; nib = 0;
        for (int n = 0; n < 16; n++) if (SEG[n] == ca) begin found = 1; nib = n; end
        if (ca == 7'h7F) found = 1;
        if (!found) begin exp_se = 1; return; end
        m_nib[k] = 4'(nib);
        m_blk[k] = (ca == 7'h7F);
        m_seen[k] = 1'b1;
        if (m_seen == 4'hF) begin
            for (int i = 0; i < 4; i++) begin
                exp_value[4*i +: 4] = m_nib[i];
                exp_blank[i] = m_blk[i];
            end
            exp_vv = 1;
            m_seen = '0;
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_reset();
            end else begin
                exp_vv = 0; exp_se = 0; exp_ae = 0;
                if (m_s2 == m_last) begin
                    if (m_run < 100000) m_run++;
                end else begin
                    m_run = 1;
                end
                m_last = m_s2;
                if (m_run == SC) m_act(m_s2);
                m_s2 = m_s1;
                m_s1 = {anode, cathode};
            end
        end
    end

    // Compare every cycle on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_value", 32'(value), 0);
                chk("rst_blank", 32'(blank), 0);
                chk("rst_pulses", {29'b0, value_valid, seg_err, anode_err}, 0);
            end else begin
                chk("value", 32'(value), 32'(exp_value));
                chk("blank", 32'(blank), 32'(exp_blank));
                chk("value_valid", 32'(value_valid), 32'(exp_vv));
                chk("seg_err", 32'(seg_err), 32'(exp_se));
                chk("anode_err", 32'(anode_err), 32'(exp_ae));
            end
            if (value_valid === 1'b1) vv_seen++;
            if (seg_err === 1'b1) se_seen++;
            if (anode_err === 1'b1) ae_seen++;
        end
    end

    task automatic drive(input logic [3:0] an, input logic [6:0] ca, input int n);
        anode = an;
        cathode = ca;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic dig(input int k, input logic [6:0] ca, input int n);
        logic [3:0] one;
        one = 4'b0001;
        drive(~(one << k), ca, n);
    endtask

    int v0, s0, a0;

    initial begin
        rst_n = 1'b0;
        anode = '1;
        cathode = '1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        drive('1, '1, 3);

        // Scan "1234" twice
        v0 = vv_seen;
        repeat (2) begin
            dig(0, SEG[4], 8); dig(1, SEG[3], 8);
            dig(2, SEG[2], 8); dig(3, SEG[1], 8);
        end
        drive('1, '1, 4);
        chk("t1_value", 32'(value), 32'h1234);
        chk("t1_model", 32'(exp_value), 32'h1234);
        chk("t1_blank", 32'(blank), 0);
        chk("t1_vv_count", vv_seen - v0, 2);

        // Glitching cathode: no sample ever completes
        v0 = vv_seen; s0 = se_seen; a0 = ae_seen;
        for (int i = 0; i < 10; i++) dig(0, (i % 2 == 0) ? SEG[5] : SEG[4], 2);
        drive('1, '1, 8);
        chk("t2_vv", vv_seen - v0, 0);
        chk("t2_se", se_seen - s0, 0);
        chk("t2_ae", ae_seen - a0, 0);

        // Invalid pattern on digit 1, then the other digits: no frame
        v0 = vv_seen; s0 = se_seen;
        dig(1, 7'b1010101, 10);
        chk("t3_se", se_seen - s0, 1);
        dig(0, SEG[1], 8); dig(2, SEG[2], 8); dig(3, SEG[3], 8);
        drive('1, '1, 4);
        chk("t3_vv", vv_seen - v0, 0);

        // Blank digit 2, others F; digit 1 completes the frame
        dig(0, SEG[15], 8); dig(2, 7'h7F, 8); dig(3, SEG[15], 8); dig(1, SEG[15], 8);
        drive('1, '1, 4);
        chk("t4_value", 32'(value), 32'hF0FF);
        chk("t4_blank", 32'(blank), 32'b0100);
        chk("t4_vv", vv_seen - v0, 1);
        a0 = ae_seen;
        drive(4'b1100, SEG[8], 10);
        drive('1, '1, 4);
        chk("t4_ae", ae_seen - a0, 1);

        // Reset mid-frame, then rescan "ABCD"
        dig(0, SEG[7], 8); dig(1, SEG[6], 8); dig(2, SEG[5], 8);
        anode = '1; cathode = '1;
        rst_n = 1'b0;
        #2;
        chk("t5_rst_value", 32'(value), 0);
        chk("t5_rst_blank", 32'(blank), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive('1, '1, 3);
        v0 = vv_seen;
        dig(0, SEG[13], 8); dig(1, SEG[12], 8); dig(2, SEG[11], 8);
        drive('1, '1, 4);
        chk("t5_partial_vv", vv_seen - v0, 0);
        chk("t5_partial_value", 32'(value), 0);
        dig(3, SEG[10], 8);
        drive('1, '1, 4);
        chk("t5_value", 32'(value), 32'hABCD);
        chk("t5_vv", vv_seen - v0, 1);

        // Back-to-back: short dwells, next digit 0 credited to the new frame
        v0 = vv_seen;
        dig(0, SEG[1], 8); dig(1, SEG[2], 8); dig(2, SEG[3], 8);
        dig(3, SEG[0], SC - 1);
        dig(3, SEG[4], SC);
        dig(0, SEG[9], SC + 1);
        chk("t6_value", 32'(value), 32'h4321);
        chk("t6_vv", vv_seen - v0, 1);
        dig(1, SEG[8], 8); dig(2, SEG[7], 8); dig(3, SEG[6], 8);
        drive('1, '1, 4);
        chk("t6_next_value", 32'(value), 32'h6789);
        chk("t6_next_vv", vv_seen - v0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
